// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the 8N1 UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

    // Bits needed to hold div-1; never less than one.
    function automatic int unsigned cnt_width(input int unsigned div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Reloadable bit-period down-counter; o_tick marks the last cycle of a symbol.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int unsigned DIV = 2,
    parameter int unsigned CW  = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    output logic o_tick
);

    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    // Parks at zero instead of wrapping, so an idle counter never ticks spuriously into a frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= RELOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/corescore_emitter_uart.sv
// Byte-wide 8N1 UART transmitter with a valid/ready handshake and registered serial output.
module corescore_emitter_uart
    import uart_pkg::*;
#(
    parameter int unsigned clk_freq_hz = 100000000,
    parameter int unsigned baud_rate   = 1000000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_uart_tx
);

    localparam int unsigned DIV = calc_div(clk_freq_hz, baud_rate);
    localparam int unsigned CW  = cnt_width(DIV);

    if (DIV < 2) begin : g_div_check
        $error("corescore_emitter_uart: clk_freq_hz / baud_rate must be at least 2");
    end

    uart_state_e r_state;
    uart_state_e w_state_next;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_idx;
    logic        r_tx;
    logic        w_tick;
    logic        w_load;

    uart_baud_counter #(
        .DIV (DIV),
        .CW  (CW)
    ) u_baud (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_load),
        .o_tick (w_tick)
    );

    // NOTE: next-state and reload get defaults first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_valid) begin
                    w_state_next = START;
                    w_load       = 1'b1;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_next = DATA;
                    w_load       = 1'b1;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_load = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // The line level for each symbol is registered on the edge that starts it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_tx      <= 1'b1;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_shift   <= i_data;
                        r_tx      <= 1'b0;
                        r_bit_idx <= 3'd0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == 3'd7) begin
                            r_tx      <= 1'b1;
                            r_bit_idx <= 3'd0;
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    r_tx <= 1'b1;
                end
                default: r_tx <= 1'b1;
            endcase
        end
    end

    assign o_ready   = (r_state == IDLE);
    assign o_uart_tx = r_tx;

endmodule

// File: tb/tb_corescore_emitter_uart.sv
// Self-checking bench: two transmitters (DIV=100 and DIV=12) against a frame-level reference model.
`timescale 1ns/1ps
module tb_corescore_emitter_uart;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       v100, v12;
    logic       rdy100, tx100, rdy12, tx12;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    corescore_emitter_uart #(
        .clk_freq_hz (100000000),
        .baud_rate   (1000000)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_data    (data),
        .i_valid   (v100),
        .o_ready   (rdy100),
        .o_uart_tx (tx100)
    );

    corescore_emitter_uart #(
        .clk_freq_hz (12000000),
        .baud_rate   (1000000)
    ) dut12 (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_data    (data),
        .i_valid   (v12),
        .o_ready   (rdy12),
        .o_uart_tx (tx12)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_valid(input bit s, input logic v);
        if (s) v12 = v;
        else   v100 = v;
    endtask

    // Called at a falling edge; the following rising edge is the acceptance edge.
    task automatic accept(input bit s, input logic [7:0] b, input bit hold);
        data = b;
        drive_valid(s, 1'b1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) drive_valid(s, 1'b0);
    endtask

    // Reference model: symbol j of a frame is {start=0, b[0..7], stop=1}[j], each lasting div cycles.
    task automatic observe(input bit s, input logic [7:0] exp, input int pulse_at,
                           input logic [7:0] pulse_b, input string tag, output int start_cyc);
        int         div;
        int         bad;
        int         rdy_hi;
        logic       tx;
        logic [7:0] dec;
        logic [9:0] frame;
        div       = s ? 12 : 100;
        bad       = 0;
        rdy_hi    = 0;
        dec       = 8'h00;
        frame     = {1'b1, exp, 1'b0};
        start_cyc = cyc;
        for (int k = 0; k < 10 * div; k++) begin
            if (pulse_at >= 0 && k == pulse_at) begin
                data = pulse_b;
                drive_valid(s, 1'b1);
            end else if (pulse_at >= 0 && k == pulse_at + 1) begin
                drive_valid(s, 1'b0);
            end
            tx = s ? tx12 : tx100;
            if (tx !== frame[k / div]) bad++;
            if ((s ? rdy12 : rdy100) !== 1'b0) rdy_hi++;
            if ((k % div) == div / 2 && (k / div) >= 1 && (k / div) <= 8) dec[k / div - 1] = tx;
            @(negedge clk);
        end
        check($sformatf("%s_wave_bad_cycles", tag), bad, 0);
        check($sformatf("%s_ready_high_in_frame", tag), rdy_hi, 0);
        check($sformatf("%s_decoded", tag), dec, exp);
        check($sformatf("%s_ready_at_end", tag), s ? rdy12 : rdy100, 1);
        check($sformatf("%s_tx_at_end", tag), s ? tx12 : tx100, 1);
    endtask

    initial begin
        int         s1, s2, bad;
        logic [7:0] b;
        rst  = 1'b1;
        data = 8'h00;
        v100 = 1'b0;
        v12  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready100", rdy100, 1);
        check("reset_tx100", tx100, 1);
        check("reset_ready12", rdy12, 1);
        check("reset_tx12", tx12, 1);

        // Reset wins over a simultaneous request.
        data = 8'hA5;
        v100 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_prio_ready", rdy100, 1);
        check("rst_prio_tx", tx100, 1);
        v100 = 1'b0;
        rst  = 1'b0;

        // First edge after release accepts.
        accept(1'b0, 8'h61, 1'b0);
        observe(1'b0, 8'h61, -1, 8'h00, "byte61", s1);

        // Request while busy is dropped; line stays idle afterwards.
        accept(1'b0, 8'h41, 1'b0);
        observe(1'b0, 8'h41, 499, 8'h42, "drop42", s1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (tx100 !== 1'b1 || rdy100 !== 1'b1) bad++;
            @(negedge clk);
        end
        check("drop42_idle_after", bad, 0);

        // Valid held: next start follows the handshake cycle in which ready is first seen high.
        accept(1'b0, 8'h0D, 1'b1);
        data = 8'h0A;
        observe(1'b0, 8'h0D, -1, 8'h00, "b2b_first", s1);
        accept(1'b0, 8'h0A, 1'b0);
        observe(1'b0, 8'h0A, -1, 8'h00, "b2b_second", s2);
        check("b2b_start_spacing", s2 - s1, 10 * 100 + 1);

        // Reset mid-frame aborts it.
        accept(1'b0, 8'h33, 1'b0);
        repeat (349) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_tx", tx100, 1);
        check("abort_ready", rdy100, 1);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (tx100 !== 1'b1) bad++;
            @(negedge clk);
        end
        check("abort_no_residue", bad, 0);
        accept(1'b0, 8'h55, 1'b0);
        observe(1'b0, 8'h55, -1, 8'h00, "after_abort55", s1);

        // DIV=12 instance.
        accept(1'b1, 8'hFF, 1'b0);
        observe(1'b1, 8'hFF, -1, 8'h00, "div12_ff", s1);

        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            accept(1'b0, b, 1'b0);
            observe(1'b0, b, -1, 8'h00, $sformatf("rnd100_%0d", n), s1);
        end
        for (int n = 0; n < 256; n++) begin
            b = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            accept(1'b1, b, 1'b0);
            observe(1'b1, b, -1, 8'h00, $sformatf("rnd12_%0d", n), s1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
